// File: rtl/alu_serial.sv
// Digit-serial ALU: executes one ALUControl operation over WIDTH/DIGIT cycles
// under valid/ready handshakes on both the request and the result side.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam logic [2:0] ADD_OP  = 3'b000;
  localparam logic [2:0] SUB_OP  = 3'b001;
  localparam logic [2:0] AND_OP  = 3'b010;
  localparam logic [2:0] OR_OP   = 3'b011;
  localparam logic [2:0] SLT_OP  = 3'b101;
  localparam logic [2:0] SLTU_OP = 3'b110;
  localparam logic [2:0] NOP_OP  = 3'b111;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             last_s;
  logic [DIGIT:0]   dig_s;
  logic [WIDTH-1:0] acc_full_s;
  logic [WIDTH-1:0] final_s;
  logic             lt_s;

  // One digit of the selected operation; bit DIGIT is the carry out.
  function automatic logic [DIGIT:0] digit_op(
    input logic [2:0]       op,
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             cin
  );
    logic [DIGIT:0] r;
    case (op)
      ADD_OP:                  r = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
      SUB_OP, SLT_OP, SLTU_OP: r = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, cin};
      AND_OP:                  r = {1'b0, a & b};
      OR_OP:                   r = {1'b0, a | b};
      NOP_OP:                  r = {(DIGIT+1){1'b0}};
      default:                 r = {(DIGIT+1){1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic uses_borrow(input logic [2:0] op);
    return (op == SUB_OP) || (op == SLT_OP) || (op == SLTU_OP);
  endfunction

  // Operands shift right each RUN cycle, so the active digit is always the low one;
  // finished digits enter the accumulator from the top.
  always_comb begin
    dig_s      = digit_op(op_r, a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
    acc_full_s = {dig_s[DIGIT-1:0], acc_r[WIDTH-1:DIGIT]};
    lt_s       = (a_msb_r != b_msb_r) ? a_msb_r : dig_s[DIGIT-1];
    case (op_r)
      SLT_OP:  final_s = {{(WIDTH-1){1'b0}}, lt_s};
      SLTU_OP: final_s = {{(WIDTH-1){1'b0}}, ~dig_s[DIGIT]};
      default: final_s = acc_full_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
          last_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture and digit-serial datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r    <= 3'b000;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      carry_r <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else if (accept_s) begin
      op_r    <= ALUControl;
      a_r     <= SrcA;
      b_r     <= SrcB;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      carry_r <= uses_borrow(ALUControl);
      a_msb_r <= SrcA[WIDTH-1];
      b_msb_r <= SrcB[WIDTH-1];
    end else if (state_r == RUN) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      acc_r   <= acc_full_s;
      carry_r <= dig_s[DIGIT];
      cnt_r   <= last_s ? CNT_ZERO : (cnt_r + CNT_ONE);
    end
  end

  // Result and Zero update only when the last digit completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
    end else if (last_s) begin
      result_r <= final_s;
      zero_r   <= (final_s == {WIDTH{1'b0}});
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Result    = result_r;
  assign Zero      = zero_r;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed plan vectors, randomized operations
// against an arithmetic reference model, backpressure and mid-run reset.
module tb_alu_serial;

  localparam int W = 32;
  localparam int LAT = 8;
  localparam logic [2:0] ADD_OP  = 3'b000;
  localparam logic [2:0] SUB_OP  = 3'b001;
  localparam logic [2:0] AND_OP  = 3'b010;
  localparam logic [2:0] OR_OP   = 3'b011;
  localparam logic [2:0] SLT_OP  = 3'b101;
  localparam logic [2:0] SLTU_OP = 3'b110;
  localparam logic [2:0] NOP_OP  = 3'b111;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   ALUControl = 3'b000;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Result;
  logic         Zero;

  int checks = 0;
  int errors = 0;

  alu_serial #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      ADD_OP:  return a + b;
      SUB_OP:  return a - b;
      AND_OP:  return a & b;
      OR_OP:   return a | b;
      SLT_OP:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU_OP: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one request, return latency (edges after accept) and the presented result.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [W-1:0] res, output logic z);
    @(negedge clk);
    in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = Result;
    z = Zero;
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Result !== 32'd0 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b Result=%h Zero=%b, want 1 0 0 0",
               in_ready, out_valid, Result, Zero);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]   ops [9] = '{ADD_OP, SUB_OP, SUB_OP, SLT_OP, SLTU_OP, SLT_OP, AND_OP, OR_OP, NOP_OP};
    logic [W-1:0] as  [9] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678};
    logic [W-1:0] bs  [9] = '{32'h00000001, 32'd5, 32'd1, 32'h00000001, 32'h00000001, 32'h7FFFFFFF,
                              32'h0FF00FF0, 32'h0FF00FF0, 32'h9ABCDEF0};
    logic [W-1:0] exp [9] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1,
                              32'h00F000F0, 32'hFFF0FFF0, 32'd0};
    int lat;
    logic [W-1:0] res;
    logic z;
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], as[i], bs[i], lat, res, z);
      checks++;
      if (res !== exp[i] || z !== (exp[i] == 32'd0) || lat != LAT) begin
        errors++;
        $display("FAIL directed[%0d]: got Result=%h Zero=%b lat=%0d, want Result=%h Zero=%b lat=%0d",
                 i, res, z, lat, exp[i], (exp[i] == 32'd0), LAT);
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL release[%0d]: got in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] res, a, b, e;
    logic z;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      e  = model(op, a, b);
      issue(op, a, b, lat, res, z);
      checks++;
      if (res !== e || z !== (e == 32'd0) || lat != LAT) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got Result=%h Zero=%b lat=%0d, want %h %b %0d",
                 i, op, a, b, res, z, lat, e, (e == 32'd0), LAT);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] res, held;
    logic z;
    issue(ADD_OP, 32'd100, 32'd23, lat, res, z);
    held = res;
    checks++;
    if (res !== 32'd123) begin
      errors++;
      $display("FAIL bp_first: got %h want %h", res, 32'd123);
    end
    @(negedge clk);
    in_valid = 1'b1; ALUControl = ADD_OP; SrcA = 32'h11110000; SrcB = 32'h00002222;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (Result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got Result=%h in_ready=%b out_valid=%b, want %h 0 1",
                 c, Result, in_ready, out_valid, held);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Result !== held) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b Result=%h, want 1 0 %h",
               in_ready, out_valid, Result, held);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got in_ready=%b want 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (Result !== 32'h11112222 || lat != LAT) begin
      errors++;
      $display("FAIL bp_pending: got Result=%h lat=%0d, want %h %0d", Result, lat, 32'h11112222, LAT);
    end
    release_result();
  endtask

  task automatic test_reset_midrun();
    int lat;
    logic [W-1:0] res;
    logic z;
    @(negedge clk);
    in_valid = 1'b1; ALUControl = ADD_OP; SrcA = 32'd7; SrcB = 32'd9;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Result !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset: got out_valid=%b in_ready=%b Result=%h, want 0 1 0",
               out_valid, in_ready, Result);
    end
    @(negedge clk); reset_n = 1'b1;
    issue(ADD_OP, 32'd2, 32'd3, lat, res, z);
    checks++;
    if (res !== 32'd5 || z !== 1'b0 || lat != LAT) begin
      errors++;
      $display("FAIL after_reset_add: got Result=%h Zero=%b lat=%0d, want 5 0 %0d", res, z, lat, LAT);
    end
    release_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
